key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Debounces and edge-detects the elevator panel's floor-request and door push-buttons. It consumes the 50 Hz square wave produced by the clock divider as a sampling strobe, not as a clock; all logic runs on the 50 MHz system clock. It delivers clean per-key levels and one-cycle press/release pulses to the request-latching and elevator control FSM downstream.

Parameters:
N_KEYS, 8, number of independent push-button inputs
STABLE_TICKS, 3, consecutive equal samples (50 Hz ticks) required to accept a level change; legal range 2..15 (3 = 60 ms)

Ports:
clk_in  input  1  50 MHz system clock; sole clock, all flops on its rising edge
rst  input  1  asynchronous, active-high reset
tick_src  input  1  50 Hz square wave from the divider (clk_out_50hz); treated as data
key_raw  input  N_KEYS  raw, asynchronous, bouncing button levels; 1 = pressed
key_level  output  N_KEYS  debounced level per key
key_press  output  N_KEYS  one clk_in cycle pulse on an accepted 0->1 change
key_release  output  N_KEYS  one clk_in cycle pulse on an accepted 1->0 change

Behaviour:
- Synchronisers: tick_src and each key_raw bit pass through a 2-flop synchroniser. All synchroniser flops reset to 0.
- Tick: tick = synced tick_src AND NOT its registered previous value. This gives a one-cycle strobe every 1,000,000 clk_in cycles.
  - The previous-value flop resets to 0, so a tick_src held high at reset release may yield one early tick. This is harmless and permitted.
- Per-key FSM, evaluated only in cycles where tick=1; otherwise state, counter and level hold:
  - IDLE (level 0): sample=1 -> cnt=1, go to PRESS_WAIT; sample=0 -> stay.
  - PRESS_WAIT (level 0):
    - sample=1 and cnt+1==STABLE_TICKS -> go to PRESSED, cnt=0.
    - sample=1 otherwise -> cnt+1.
    - sample=0 -> go to IDLE, cnt=0.
  - PRESSED (level 1): sample=0 -> cnt=1, go to RELEASE_WAIT; sample=1 -> stay.
  - RELEASE_WAIT (level 1): mirror of PRESS_WAIT with sample inverted. On acceptance go to IDLE. On sample=1 return to PRESSED, cnt=0.
- Outputs are registered:
  - key_level is 1 in PRESSED and RELEASE_WAIT.
  - key_press/key_release assert in the clk_in cycle after the tick that causes the transition into PRESSED/IDLE respectively, for exactly 1 cycle.
- Latency: a clean press is accepted on the STABLE_TICKS-th consecutive tick sampling 1. The key sample lags key_raw by 2 cycles (synchroniser); the pulse follows the accepting tick by 1 cycle.
- Glitches shorter than the tick spacing that do not straddle a tick have no effect.
- Counter width is $clog2(STABLE_TICKS+1). The counter never exceeds STABLE_TICKS-1 and never wraps.
- Keys are fully independent. Simultaneous acceptances on several keys pulse in the same cycle.
- Reset, including mid-operation, immediately forces:
  - all FSMs to IDLE and all counters to 0;
  - key_level, key_press, key_release to 0.
  A key still held at reset release is re-accepted after STABLE_TICKS ticks with a fresh key_press.
- key_press and key_release for one key are never asserted in the same cycle.

Decomposition:
- Shared package elevator_pkg holds:
  - the N_KEYS default;
  - the debounce state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, 2-bit encoding);
  - the STABLE_TICKS default.
- Sub-module key_debounce_cell contains one key's synchroniser, counter and FSM, and takes the shared tick as input.
- The top level holds the tick edge detector and a generate loop of N_KEYS cells.

Test Plan:
For simulation, tick_src is driven as a square wave with a 20-cycle period, so one tick occurs every 20 clk_in cycles.
1. Reset: rst=1 with key_raw=8'hFF -> all outputs 0 throughout reset. Release rst -> key_press=8'hFF for one cycle after the 3rd tick, then key_level=8'hFF.
2. Clean press/release of key 0 held for 5 ticks -> key_press[0] one cycle after the 3rd tick, and key_level[0]=1. Drop key 0 -> key_release[0] one cycle after the 3rd zero-sampling tick, and key_level[0]=0.
3. Bounce on key 2, tick samples 1,0,1,1,0 -> no key_press[2], and key_level[2] stays 0. Then hold 1 for 3 ticks -> exactly one key_press[2].
4. Glitch on key 1: high for 4 cycles placed midway between ticks -> no change on any output.
5. Reset mid-operation: key 3 PRESSED, assert rst for 5 cycles -> key_level[3]=0 in the same cycle (asynchronous). Release with key 3 still high -> key_press[3] after 3 ticks.
6. Simultaneous: keys 0 and 7 rise in the same cycle -> key_press=8'h81 in a single cycle. Releases one tick apart -> separate key_release pulses one tick apart.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator panel logic.
//   N_KEYS_DEF       : default number of panel push-buttons
//   STABLE_TICKS_DEF : default number of consecutive equal 50 Hz samples
//                      needed to accept a level change (3 = 60 ms)
//   deb_state_t      : per-key debounce FSM state
package elevator_pkg;

    localparam int N_KEYS_DEF       = 8;
    localparam int STABLE_TICKS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One push-button: 2-flop synchroniser, stability counter and debounce FSM.
// The FSM only advances in cycles where the shared strobe `tick` is high.
//   clk_in      : system clock
//   rst         : asynchronous active-high reset
//   tick        : one-cycle sampling strobe shared by all keys
//   key_raw     : raw asynchronous button level (1 = pressed)
//   key_level   : registered debounced level
//   key_press   : one-cycle pulse after an accepted 0->1 change
//   key_release : one-cycle pulse after an accepted 1->0 change
module key_debounce_cell
    import elevator_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [1:0]    sync_q;
    logic          sample;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          accept;
    logic          press_d, release_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], key_raw};
    end

    assign sample  = sync_q[1];
    // cnt_q never exceeds STABLE_TICKS-1, so the increment cannot wrap.
    assign cnt_inc = cnt_q + 1'b1;
    assign accept  = (cnt_inc == CW'(STABLE_TICKS));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (sample) begin
                        cnt_d   = CW'(1);
                        state_d = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!sample) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (accept) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                        press_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!sample) begin
                        cnt_d   = CW'(1);
                        state_d = RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (sample) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else if (accept) begin
                        cnt_d     = '0;
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so level and pulse
    // appear together in the cycle after the accepting tick.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Elevator panel key debouncer. Turns the 50 Hz divider output into a
// one-cycle sampling strobe and feeds it to N_KEYS independent debounce cells.
//   clk_in      : 50 MHz system clock (sole clock)
//   rst         : asynchronous active-high reset
//   tick_src    : 50 Hz square wave, treated as data
//   key_raw     : raw button levels, 1 = pressed
//   key_level   : debounced levels
//   key_press   : one-cycle pulses on accepted presses
//   key_release : one-cycle pulses on accepted releases
module key_debounce
    import elevator_pkg::*;
#(
    parameter int N_KEYS       = N_KEYS_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              tick_src,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    logic [1:0] tick_sync;
    logic       tick_prev;
    logic       tick;

    // tick_prev resets to 0, so a tick_src already high at reset release
    // can produce one early strobe; the debounce counters tolerate that.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_sync <= '0;
            tick_prev <= 1'b0;
        end else begin
            tick_sync <= {tick_sync[0], tick_src};
            tick_prev <= tick_sync[1];
        end
    end

    assign tick = tick_sync[1] & ~tick_prev;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk_in     (clk_in),
            .rst        (rst),
            .tick       (tick),
            .key_raw    (key_raw[g]),
            .key_level  (key_level[g]),
            .key_press  (key_press[g]),
            .key_release(key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    localparam int N  = 8;
    localparam int ST = 3;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         tick_src;
    logic [N-1:0] key_raw;
    logic [N-1:0] key_level, key_press, key_release;

    key_debounce #(.N_KEYS(N), .STABLE_TICKS(ST)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tick_src   (tick_src),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk_in = ~clk_in;

    int n_assert = 0;
    int n_fail   = 0;
    int phase    = 0;
    int cyc      = 0;
    int press_cnt [N];
    int rel_cnt   [N];
    int last_rel  [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the DUT sees inputs two edges late, and a strobe
    // whenever the delayed tick_src goes 0->1. A key's level flips once
    // ST consecutive strobes have sampled the opposite value.
    logic         td [1:3];
    logic [N-1:0] kd [1:3];
    logic [N-1:0] m_lvl, m_press, m_rel;
    int           run [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; last_rel[i] = 0; run[i] = 0;
        end
        for (int j = 1; j <= 3; j++) begin td[j] = 1'b0; kd[j] = '0; end
        m_lvl = '0; m_press = '0; m_rel = '0;
    end

    always @(posedge clk_in) begin
        logic         tk;
        logic [N-1:0] smp;
        #1;
        cyc++;
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            for (int j = 1; j <= 3; j++) begin td[j] = 1'b0; kd[j] = '0; end
            m_lvl = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            tk  = td[2] & ~td[3];
            smp = kd[2];
            if (tk) begin
                for (int i = 0; i < N; i++) begin
                    if (smp[i] != m_lvl[i]) begin
                        run[i]++;
                        if (run[i] == ST) begin
                            run[i]   = 0;
                            m_lvl[i] = ~m_lvl[i];
                            if (m_lvl[i]) m_press[i] = 1'b1;
                            else          m_rel[i]   = 1'b1;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
            end
            td[3] = td[2]; td[2] = td[1]; td[1] = tick_src;
            kd[3] = kd[2]; kd[2] = kd[1]; kd[1] = key_raw;
        end
        chk("level",   key_level,   m_lvl);
        chk("press",   key_press,   m_press);
        chk("release", key_release, m_rel);
        chk("overlap", key_press & key_release, 0);
        for (int i = 0; i < N; i++) begin
            if (key_press[i])   press_cnt[i]++;
            if (key_release[i]) begin rel_cnt[i]++; last_rel[i] = cyc; end
        end
    end

    // All stimulus changes happen on the falling edge; tick_src is a
    // 20-cycle square wave high for phases 10..19.
    task automatic step();
        @(negedge clk_in);
        phase    = (phase == 19) ? 0 : phase + 1;
        tick_src = (phase >= 10);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Keys set at phase 0 are sampled by the strobe of that window.
    task automatic align();
        step();
        while (phase != 0) step();
    endtask

    task automatic wait_press(input int lim);
        for (int i = 0; i < lim && key_press == '0; i++) step();
    endtask

    int p0, r0, r7;

    initial begin
        rst = 1'b1; tick_src = 1'b0; key_raw = 8'hFF;

        // 1: reset with all keys held, then re-acceptance
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t1_rst_level", key_level, 0);
            chk("t1_rst_press", key_press, 0);
        end
        rst = 1'b0;
        wait_press(120);
        chk("t1_press_all", key_press, 8'hFF);
        step();
        chk("t1_press_once", key_press, 0);
        chk("t1_level_all", key_level, 8'hFF);
        key_raw = '0;
        steps(120);
        chk("t1_released", key_level, 0);

        // 2: clean press / release of key 0
        align();
        p0 = press_cnt[0]; r0 = rel_cnt[0];
        key_raw[0] = 1'b1;
        steps(100);
        chk("t2_press_cnt", press_cnt[0] - p0, 1);
        chk("t2_level", key_level, 8'h01);
        key_raw[0] = 1'b0;
        steps(100);
        chk("t2_rel_cnt", rel_cnt[0] - r0, 1);
        chk("t2_level0", key_level, 0);

        // 3: bounce on key 2 (samples 1,0,1,1,0), then a clean hold
        align();
        p0 = press_cnt[2];
        key_raw[2] = 1'b1; steps(20);
        key_raw[2] = 1'b0; steps(20);
        key_raw[2] = 1'b1; steps(40);
        key_raw[2] = 1'b0; steps(20);
        chk("t3_bounce_cnt", press_cnt[2] - p0, 0);
        chk("t3_bounce_lvl", key_level, 0);
        key_raw[2] = 1'b1; steps(80);
        chk("t3_hold_cnt", press_cnt[2] - p0, 1);
        chk("t3_hold_lvl", key_level, 8'h04);
        key_raw[2] = 1'b0; steps(100);

        // 4: 4-cycle glitch on key 1 between strobes
        align();
        p0 = press_cnt[1];
        key_raw[1] = 1'b1; steps(4);
        key_raw[1] = 1'b0; steps(60);
        chk("t4_glitch_cnt", press_cnt[1] - p0, 0);
        chk("t4_glitch_lvl", key_level, 0);

        // 5: reset while key 3 is pressed
        align();
        key_raw[3] = 1'b1; steps(80);
        chk("t5_pressed", key_level, 8'h08);
        step();
        rst = 1'b1;
        #1;
        chk("t5_async_lvl", key_level, 0);
        steps(5);
        rst = 1'b0;
        p0 = press_cnt[3];
        steps(100);
        chk("t5_repress_cnt", press_cnt[3] - p0, 1);
        chk("t5_repress_lvl", key_level, 8'h08);
        key_raw[3] = 1'b0; steps(100);

        // 6: simultaneous presses, staggered releases
        align();
        key_raw = 8'h81;
        wait_press(100);
        chk("t6_press_both", key_press, 8'h81);
        steps(40);
        align();
        r0 = rel_cnt[0]; r7 = rel_cnt[7];
        key_raw[0] = 1'b0; steps(20);
        key_raw[7] = 1'b0; steps(100);
        chk("t6_rel0_cnt", rel_cnt[0] - r0, 1);
        chk("t6_rel7_cnt", rel_cnt[7] - r7, 1);
        chk("t6_rel_gap", last_rel[7] - last_rel[0], 20);
        chk("t6_level0", key_level, 0);

        steps(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
